inference_scheduler: RTL and testbench

INFERENCE_SCHEDULER -- requirements
Module: inference_scheduler

---
 rtl/inference_scheduler.sv | 161 ++++++++++++++++
 tb/tb_inference_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_scheduler.sv
// Tile sequencer for the systolic array: waits for BISR recovery, loads weights and
// activations, then issues row reads and accumulator writes for one tile.
module inference_scheduler #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
  parameter int ARRAY_LATENCY = 2 * SYSTOLIC_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  test_mode,
  input  logic                  recovery_done,
  input  logic                  recovery_success,
  output logic                  weight_req,
  input  logic                  weight_valid,
  input  logic                  act_valid,
  output logic                  act_ready,
  output logic                  act_wr_en,
  output logic [ADDR_WIDTH-1:0] act_wr_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_index,
  output logic                  acc_wr_en,
  output logic [ADDR_WIDTH-1:0] acc_wr_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // One counter width covers the whole RUN window so c never wraps inside a tile.
  localparam int CNT_W = $clog2(ARRAY_LATENCY + SYSTOLIC_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(SYSTOLIC_SIZE - 1);
  localparam logic [CNT_W-1:0] RD_END    = CNT_W'(SYSTOLIC_SIZE);
  localparam logic [CNT_W-1:0] ACC_BEG   = CNT_W'(ARRAY_LATENCY);
  localparam logic [CNT_W-1:0] ACC_END   = CNT_W'(ARRAY_LATENCY + SYSTOLIC_SIZE);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(ARRAY_LATENCY + SYSTOLIC_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REC,
    LOAD_W,
    LOAD_A,
    RUN,
    DONE,
    ERROR
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  state_t           w_rec_target;
  logic [CNT_W-1:0] r_w_cnt;
  logic [CNT_W-1:0] w_w_cnt_next;
  logic [CNT_W-1:0] r_a_cnt;
  logic [CNT_W-1:0] w_a_cnt_next;
  logic [CNT_W-1:0] r_c_cnt;
  logic [CNT_W-1:0] w_c_cnt_next;
  logic [CNT_W-1:0] w_acc_off;
  logic             w_abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_w_cnt <= '0;
      r_a_cnt <= '0;
      r_c_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_w_cnt <= w_w_cnt_next;
      r_a_cnt <= w_a_cnt_next;
      r_c_cnt <= w_c_cnt_next;
    end
  end

  // Where a start lands depends on how far BISR recovery has got.
  always_comb begin
    w_rec_target = WAIT_REC;
    if (recovery_done) begin
      w_rec_target = recovery_success ? LOAD_W : ERROR;
    end
  end

  assign w_abort = test_mode && (r_state != IDLE) && (r_state != ERROR);

  always_comb begin
    w_state_next = r_state;
    w_w_cnt_next = r_w_cnt;
    w_a_cnt_next = r_a_cnt;
    w_c_cnt_next = r_c_cnt;
    case (r_state)
      IDLE, ERROR: begin
        if (start && !test_mode) begin
          w_state_next = w_rec_target;
        end
      end
      WAIT_REC: begin
        if (recovery_done) begin
          w_state_next = recovery_success ? LOAD_W : ERROR;
        end
      end
      LOAD_W: begin
        if (weight_valid) begin
          if (r_w_cnt == LAST_BEAT) begin
            w_state_next = LOAD_A;
            w_w_cnt_next = '0;
          end else begin
            w_w_cnt_next = r_w_cnt + 1'b1;
          end
        end
      end
      LOAD_A: begin
        if (act_valid) begin
          if (r_a_cnt == LAST_BEAT) begin
            w_state_next = RUN;
            w_a_cnt_next = '0;
          end else begin
            w_a_cnt_next = r_a_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        if (r_c_cnt == RUN_LAST) begin
          w_state_next = DONE;
          w_c_cnt_next = '0;
        end else begin
          w_c_cnt_next = r_c_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // BIST takeover wins over everything the tile was doing.
    if (w_abort) begin
      w_state_next = IDLE;
      w_w_cnt_next = '0;
      w_a_cnt_next = '0;
      w_c_cnt_next = '0;
    end
  end

  assign w_acc_off = r_c_cnt - ACC_BEG;

  // Strobes drop in the very cycle test_mode rises, before the state register follows.
  always_comb begin
    weight_req  = (r_state == LOAD_W) && !test_mode;
    act_ready   = (r_state == LOAD_A) && !test_mode;
    act_wr_en   = act_ready && act_valid;
    act_wr_addr = act_ready ? ADDR_WIDTH'(r_a_cnt) : '0;
    rd_en       = (r_state == RUN) && !test_mode && (r_c_cnt < RD_END);
    rd_index    = rd_en ? ADDR_WIDTH'(r_c_cnt) : '0;
    acc_wr_en   = (r_state == RUN) && !test_mode && (r_c_cnt >= ACC_BEG) && (r_c_cnt < ACC_END);
    acc_wr_addr = acc_wr_en ? ADDR_WIDTH'(w_acc_off) : '0;
    busy        = (r_state == WAIT_REC) || (r_state == LOAD_W) ||
                  (r_state == LOAD_A) || (r_state == RUN);
    done        = (r_state == DONE) && !test_mode;
    error       = (r_state == ERROR);
  end

endmodule

// File: tb/tb_inference_scheduler.sv
// Scoreboard bench for inference_scheduler: expected addresses and done cycles are queued
// when a tile is driven and popped whenever the matching strobe appears.
module tb_inference_scheduler;
  localparam int S   = 8;
  localparam int LAT = 16;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          test_mode;
  logic          recovery_done;
  logic          recovery_success;
  logic          weight_req;
  logic          weight_valid;
  logic          act_valid;
  logic          act_ready;
  logic          act_wr_en;
  logic [AW-1:0] act_wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_index;
  logic          acc_wr_en;
  logic [AW-1:0] acc_wr_addr;
  logic          busy;
  logic          done;
  logic          error;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int q_act[$];
  int q_rd[$];
  int q_acc[$];
  int q_done[$];

  always #5 clk = ~clk;

  inference_scheduler #(
    .SYSTOLIC_SIZE(S),
    .ADDR_WIDTH(AW),
    .ARRAY_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .test_mode(test_mode),
    .recovery_done(recovery_done),
    .recovery_success(recovery_success),
    .weight_req(weight_req),
    .weight_valid(weight_valid),
    .act_valid(act_valid),
    .act_ready(act_ready),
    .act_wr_en(act_wr_en),
    .act_wr_addr(act_wr_addr),
    .rd_en(rd_en),
    .rd_index(rd_index),
    .acc_wr_en(acc_wr_en),
    .acc_wr_addr(acc_wr_addr),
    .busy(busy),
    .done(done),
    .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic monitor();
    if (act_wr_en) begin
      if (q_act.size() == 0) check("act_wr_unexpected", 32'(act_wr_en), 32'd0);
      else check("act_wr_addr", 32'(act_wr_addr), q_act.pop_front());
    end
    if (rd_en) begin
      if (q_rd.size() == 0) check("rd_unexpected", 32'(rd_en), 32'd0);
      else check("rd_index", 32'(rd_index), q_rd.pop_front());
    end
    if (acc_wr_en) begin
      if (q_acc.size() == 0) check("acc_unexpected", 32'(acc_wr_en), 32'd0);
      else check("acc_wr_addr", 32'(acc_wr_addr), q_acc.pop_front());
    end
    if (done) begin
      $display("tile done at cycle %0d", cyc);
      if (q_done.size() == 0) check("done_unexpected", 32'(done), 32'd0);
      else check("done_cycle", cyc, q_done.pop_front());
    end
  endtask

  task automatic observe();
    @(negedge clk);
    monitor();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_tile();
    for (int i = 0; i < S; i++) begin
      q_rd.push_back(i);
      q_acc.push_back(i);
    end
  endtask

  // Called in the first LOAD_W cycle; drives weights, activations and watches RUN.
  task automatic feed_tile(input bit stall, input int start_at, input int abort_at);
    int beats;
    bit phase;
    int t0;
    for (int i = 0; i < S; i++) begin
      weight_valid = 1'b1;
      observe();
      check("w_phase", 32'({busy, error, weight_req, act_ready}), 32'b1010);
      tick();
    end
    weight_valid = 1'b0;
    beats = 0;
    phase = 1'b1;
    while (beats < S) begin
      act_valid = stall ? phase : 1'b1;
      if (act_valid) q_act.push_back(beats);
      observe();
      check("a_phase", 32'({busy, weight_req, act_ready, rd_en}), 32'b1010);
      tick();
      if (act_valid) beats++;
      phase = ~phase;
    end
    act_valid = 1'b0;
    t0 = cyc;
    q_done.push_back(t0 + LAT + S);
    for (int k = 0; k <= LAT + S; k++) begin
      start = (k == start_at) || (start_at >= 0 && k == LAT + S);
      if (k == abort_at) begin
        test_mode = 1'b1;
        observe();
        check("abort_strobes",
              32'({rd_en, acc_wr_en, done, weight_req, act_ready, act_wr_en}), 32'd0);
        tick();
        test_mode = 1'b0;
        start = 1'b0;
        q_acc.delete();
        q_rd.delete();
        q_done.delete();
        observe();
        check("abort_idle", 32'({busy, done, error}), 32'd0);
        tick();
        return;
      end
      observe();
      check("run_rd_en", 32'(rd_en), 32'(k < S));
      check("run_acc_en", 32'(acc_wr_en), 32'(k >= LAT && k < LAT + S));
      check("run_busy", 32'(busy), 32'(k < LAT + S));
      tick();
    end
    start = 1'b0;
    observe();
    check("post_idle", 32'({busy, done, weight_req}), 32'd0);
    tick();
    check("queues_drained", q_act.size() + q_rd.size() + q_acc.size() + q_done.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_mode = 1'b0;
    recovery_done = 1'b0;
    recovery_success = 1'b0;
    weight_valid = 1'b0;
    act_valid = 1'b0;
    tick();
    tick();
    observe();
    check("reset_flags",
          32'({weight_req, act_ready, act_wr_en, rd_en, acc_wr_en, busy, done, error}), 32'd0);
    check("reset_addrs", 32'({act_wr_addr, rd_index, acc_wr_addr}), 32'd0);
    tick();
    rst_n = 1'b1;

    // Nominal tile with recovery already complete.
    recovery_done = 1'b1;
    recovery_success = 1'b1;
    start = 1'b1;
    observe();
    check("idle_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    expect_tile();
    feed_tile(1'b0, -1, -1);

    // test_mode inhibits a start in IDLE.
    start = 1'b1;
    test_mode = 1'b1;
    observe();
    tick();
    start = 1'b0;
    test_mode = 1'b0;
    observe();
    check("tm_inhibit_busy", 32'(busy), 32'd0);
    tick();

    // Recovery pending for ten cycles, then stalled activations.
    recovery_done = 1'b0;
    recovery_success = 1'b0;
    start = 1'b1;
    observe();
    tick();
    start = 1'b0;
    expect_tile();
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) begin
        recovery_done = 1'b1;
        recovery_success = 1'b1;
      end
      observe();
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_wreq", 32'(weight_req), 32'd0);
      tick();
    end
    feed_tile(1'b1, -1, -1);

    // Recovery failure, sticky error, then a successful retry.
    recovery_success = 1'b0;
    start = 1'b1;
    observe();
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      observe();
      check("err_flags", 32'({error, busy, weight_req}), 32'b100);
      tick();
    end
    start = 1'b1;
    test_mode = 1'b1;
    observe();
    tick();
    start = 1'b0;
    test_mode = 1'b0;
    observe();
    check("err_tm_hold", 32'(error), 32'd1);
    tick();
    recovery_success = 1'b1;
    start = 1'b1;
    observe();
    check("err_before_retry", 32'(error), 32'd1);
    tick();
    start = 1'b0;
    expect_tile();
    feed_tile(1'b0, -1, -1);

    // test_mode abort at RUN c=20.
    start = 1'b1;
    observe();
    tick();
    start = 1'b0;
    expect_tile();
    feed_tile(1'b0, -1, 20);

    // start during RUN and in DONE is ignored; counters must have cleared after the abort.
    start = 1'b1;
    observe();
    tick();
    start = 1'b0;
    expect_tile();
    feed_tile(1'b0, 5, -1);

    // Reset in the middle of LOAD_A.
    start = 1'b1;
    observe();
    tick();
    start = 1'b0;
    expect_tile();
    for (int i = 0; i < S; i++) begin
      weight_valid = 1'b1;
      observe();
      tick();
    end
    weight_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      act_valid = 1'b1;
      q_act.push_back(i);
      observe();
      tick();
    end
    act_valid = 1'b0;
    rst_n = 1'b0;
    observe();
    tick();
    act_valid = 1'b1;
    weight_valid = 1'b1;
    start = 1'b1;
    observe();
    check("rst_mid_flags",
          32'({weight_req, act_ready, act_wr_en, rd_en, acc_wr_en, busy, done, error}), 32'd0);
    check("rst_mid_addrs", 32'({act_wr_addr, rd_index, acc_wr_addr}), 32'd0);
    tick();
    rst_n = 1'b1;
    act_valid = 1'b0;
    weight_valid = 1'b0;
    start = 1'b0;
    check("rst_act_drained", q_act.size(), 32'd0);
    q_rd.delete();
    q_acc.delete();
    observe();
    check("rst_after_busy", 32'(busy), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
